// File: rtl/cnt_pkg.sv
// cnt_pkg: shared state encoding and width defaults for the counter timer arbiter.
package cnt_pkg;
  localparam int CNT_W_DEF = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req at or above rr_ptr (mod NUM_REQ).
module rr_arbiter
  import cnt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt_nxt,
  output logic [IW-1:0]      idx
);
  always_comb begin
    int j;
    logic found;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx = IW'(j);
      end
    end
    gnt_nxt = found ? (NUM_REQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/cnt_timer_arb.sv
// cnt_timer_arb: one down-counter shared round-robin between NUM_REQ requesters as a cycle timer.
module cnt_timer_arb
  import cnt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         o_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_n;
  logic [IW-1:0] own, own_n, rr_ptr, ptr_n, idx, nxt_ptr;
  logic [NUM_REQ-1:0] gnt_nxt, grant_n, done_n;
  logic busy_n;
  logic [CNT_W-1:0] cnt_n;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req),
    .rr_ptr(rr_ptr),
    .gnt_nxt(gnt_nxt),
    .idx(idx)
  );
  assign nxt_ptr = (own == IW'(NUM_REQ - 1)) ? '0 : own + IW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      own    <= '0;
      rr_ptr <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      o_cnt  <= '0;
    end else begin
      state  <= state_n;
      own    <= own_n;
      rr_ptr <= ptr_n;
      grant  <= grant_n;
      done   <= done_n;
      busy   <= busy_n;
      o_cnt  <= cnt_n;
    end
  always_comb begin
    state_n = state;
    own_n   = own;
    ptr_n   = rr_ptr;
    grant_n = grant;
    done_n  = '0;
    busy_n  = busy;
    cnt_n   = o_cnt;
    case (state)
      IDLE:
        if (|req) begin
          state_n = RUN;
          own_n   = idx;
          grant_n = gnt_nxt;
          busy_n  = 1'b1;
          cnt_n   = req_len[int'(idx)*CNT_W +: CNT_W];
        end
      RUN:
        // An owner dropping req aborts without a done pulse.
        if (!req[own]) begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
          cnt_n   = '0;
          ptr_n   = nxt_ptr;
        end else if (o_cnt != '0) begin
          cnt_n = o_cnt - CNT_W'(1);
        end else begin
          state_n = DONE;
          done_n  = grant;
        end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
        ptr_n   = nxt_ptr;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cnt_timer_arb.sv
// tb_cnt_timer_arb: table-driven and scoreboarded checks of the shared counter timer arbiter.
module tb_cnt_timer_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [15:0] req_len;
  logic [3:0] grant, done, o_cnt;
  logic busy;
  int tests = 0;
  int failed = 0;
  typedef struct {
    logic [3:0]  req;
    logic [15:0] lens;
    logic [3:0]  exp_g;
    logic [3:0]  exp_len;
  } vec_t;
  typedef struct {
    logic [3:0] g;
    logic [3:0] len;
  } exp_t;
  vec_t tbl[6];
  exp_t sb[$];
  cnt_timer_arb #(.NUM_REQ(4), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_len(req_len),
    .grant(grant),
    .done(done),
    .busy(busy),
    .o_cnt(o_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_grant"}, grant, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_cnt"}, o_cnt, 0);
  endtask
  task automatic run_txn(input logic [3:0] r, input logic [15:0] lens, input logic [3:0] eg, input logic [3:0] el);
    exp_t e;
    int n;
    req = r;
    req_len = lens;
    sb.push_back('{eg, el});
    n = 0;
    do begin @(negedge clk); n++; end while (grant == 0 && n < 20);
    chk("latency", n, 1);
    e = sb.pop_front();
    chk("grant", grant, e.g);
    chk("busy", busy, 1);
    chk("load", o_cnt, e.len);
    for (int k = int'(e.len) - 1; k >= 0; k--) begin
      @(negedge clk);
      chk("count", o_cnt, k);
      chk("no_done", done, 0);
      chk("hold", grant, e.g);
    end
    @(negedge clk);
    chk("done", done, e.g);
    chk("done_grant", grant, e.g);
    chk("done_cnt", o_cnt, 0);
    req = '0;
    @(negedge clk);
    chk("release", grant, 0);
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, m;
    exp_t e;
    tbl[0] = '{4'b0001, 16'h0003, 4'b0001, 4'd3};
    tbl[1] = '{4'b0100, 16'hF0F9, 4'b0100, 4'd0};
    tbl[2] = '{4'b0011, 16'h0052, 4'b0001, 4'd2};
    tbl[3] = '{4'b1001, 16'h1007, 4'b1000, 4'd1};
    tbl[4] = '{4'b1010, 16'h6040, 4'b0010, 4'd4};
    tbl[5] = '{4'b0001, 16'h000F, 4'b0001, 4'd15};
    rst_n = 1'b0;
    req = '0;
    req_len = '0;
    @(negedge clk);
    chk_zero("in_reset");
    #10 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("after_reset");
    foreach (tbl[i]) run_txn(tbl[i].req, tbl[i].lens, tbl[i].exp_g, tbl[i].exp_len);
    // Abort: owner 1 drops req mid-count; late len change and other req must be ignored.
    req = 4'b0010;
    req_len = 16'h0090;
    @(negedge clk);
    chk("abort_grant", grant, 4'b0010);
    chk("abort_load", o_cnt, 9);
    req_len = 16'h00F0;
    req = 4'b0011;
    n = 0;
    while (o_cnt != 5 && n < 20) begin @(negedge clk); n++; end
    chk("abort_steps", n, 4);
    chk("abort_owner", grant, 4'b0010);
    req = 4'b0001;
    @(negedge clk);
    chk_zero("abort");
    req = 4'b0101;
    req_len = 16'h0801;
    @(negedge clk);
    chk("after_abort_winner", grant, 4'b0100);
    chk("after_abort_load", o_cnt, 8);
    n = 0;
    while (o_cnt != 6 && n < 20) begin @(negedge clk); n++; end
    chk("mid_run_cnt", o_cnt, 6);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    chk_zero("held_reset");
    rst_n = 1'b1;
    run_txn(4'b0101, 16'h0801, 4'b0001, 4'd1);
    // Round robin with all requests held: pointer now at 1.
    req = 4'b1111;
    req_len = 16'h1111;
    for (int k = 0; k < 5; k++) sb.push_back('{4'b0001 << ((1 + k) % 4), 4'd1});
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (grant == 0 && n < 20) begin @(negedge clk); n++; end
      chk("rr_gap", n, 1);
      e = sb.pop_front();
      chk("rr_grant", grant, e.g);
      m = 0;
      while (grant == e.g && m < 20) begin m++; @(negedge clk); end
      chk("rr_len", m, int'(e.len) + 2);
    end
    req = '0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
